// File: rtl/leve1_pkg.sv
// Shared types and constants for the decode-stage write-back path.
package leve1_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_NUM_REG = 32;
    localparam int REG_W       = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    // x0 is hard-wired zero: never tracked as pending, never written.
    localparam reg_idx_t REG_ZERO = '0;

    // One register-file write request, as seen by decode's forwarding logic.
    typedef struct packed {
        logic                we;
        reg_idx_t            wa;
        logic [DEF_XLEN-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/leve1_wb_fifo.sv
// Small synchronous FIFO for buffered long-latency completions.
// Head is read combinationally so the arbiter can pop and register it in one edge.
module leve1_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty.
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_ok   = push && (!full || pop);
    assign pop_ok    = pop && !empty;
    assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; reset empties the buffer and drops anything stored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/leve1_wb_sched.sv
// Write-back scheduler: arbitrates the single register-file write port between
// the ALU path and buffered long-latency completions, and stalls decode on
// hazards against outstanding long-latency destinations.
module leve1_wb_sched
    import leve1_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NUM_REG  = DEF_NUM_REG,
    parameter int LL_DEPTH = 2,
    parameter int MAX_LL   = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ID_VALID,
    input  reg_idx_t        ID_RS1,
    input  reg_idx_t        ID_RS2,
    input  reg_idx_t        ID_RD,
    input  logic            ID_WE,
    input  logic            ID_LL,
    input  logic            ID_FLUSH,
    output logic            ID_STALL,
    input  logic            ALU_WVALID,
    input  reg_idx_t        ALU_WA,
    input  logic [XLEN-1:0] ALU_WD,
    input  logic            LL_VALID,
    output logic            LL_READY,
    input  reg_idx_t        LL_WA,
    input  logic [XLEN-1:0] LL_WD,
    output logic            WB_WE,
    output reg_idx_t        WB_WA,
    output logic [XLEN-1:0] WB_WD,
    output logic            BUSY
);

    localparam int COUNT_W = $clog2(MAX_LL + 1);
    localparam int ENT_W   = REG_W + XLEN;

    logic [NUM_REG-1:0] pend_reg, pend_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               wb_we_reg, wb_we_next;
    reg_idx_t           wb_wa_reg, wb_wa_next;
    logic [XLEN-1:0]    wb_wd_reg, wb_wd_next;

    logic               fifo_full, fifo_empty;
    logic [ENT_W-1:0]   fifo_head;
    reg_idx_t           head_wa;
    logic [XLEN-1:0]    head_wd;
    logic               push, pop;
    logic               raw_hz, waw_hz, cap_hz;
    logic               issue_ll, set_en;

    assign {head_wa, head_wd} = fifo_head;

    // Hazard detection against registered pending bits (set is visible next cycle).
    always_comb begin
        raw_hz = (ID_RS1 != REG_ZERO && pend_reg[ID_RS1]) ||
                 (ID_RS2 != REG_ZERO && pend_reg[ID_RS2]);
        waw_hz = ID_WE && ID_RD != REG_ZERO && pend_reg[ID_RD];
        cap_hz = ID_LL && (count_reg == COUNT_W'(MAX_LL) || fifo_full);
    end

    assign ID_STALL = RST || (ID_VALID && (raw_hz || waw_hz || cap_hz));
    assign issue_ll = ID_VALID && !ID_STALL && !ID_FLUSH && ID_LL;
    assign set_en   = issue_ll && ID_WE && ID_RD != REG_ZERO;
    assign LL_READY = !fifo_full && !RST;
    assign push     = LL_VALID && LL_READY;
    assign BUSY     = (count_reg != '0);

    leve1_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (LL_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data ({LL_WA, LL_WD}),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write-port arbitration: ALU always wins, otherwise drain the FIFO head.
    always_comb begin
        pop        = 1'b0;
        wb_we_next = 1'b0;
        wb_wa_next = wb_wa_reg;
        wb_wd_next = wb_wd_reg;
        if (ALU_WVALID) begin
            wb_we_next = (ALU_WA != REG_ZERO);
            wb_wa_next = ALU_WA;
            wb_wd_next = ALU_WD;
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            wb_we_next = (head_wa != REG_ZERO);
            wb_wa_next = head_wa;
            wb_wd_next = head_wd;
        end
    end

    // Per-register scoreboard: clear on pop, then set on issue (set wins).
    for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_pend
        assign pend_next[gi] = (set_en && ID_RD == reg_idx_t'(gi)) ||
                               (pend_reg[gi] && !(pop && head_wa == reg_idx_t'(gi)));
    end

    // Outstanding count: simultaneous issue and pop cancel out.
    always_comb begin
        count_next = count_reg;
        if (issue_ll && !pop)      count_next = count_reg + COUNT_W'(1);
        else if (!issue_ll && pop) count_next = count_reg - COUNT_W'(1);
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_reg  <= '0;
            count_reg <= '0;
            wb_we_reg <= 1'b0;
            wb_wa_reg <= REG_ZERO;
            wb_wd_reg <= '0;
        end else begin
            pend_reg  <= pend_next;
            count_reg <= count_next;
            wb_we_reg <= wb_we_next;
            wb_wa_reg <= wb_wa_next;
            wb_wd_reg <= wb_wd_next;
        end
    end

    assign WB_WE = wb_we_reg;
    assign WB_WA = wb_wa_reg;
    assign WB_WD = wb_wd_reg;

    // An ALU write to a register still owed by a long-latency op is illegal.
    alu_to_pending_reg: assert property (@(posedge CLK) disable iff (RST)
        !(ALU_WVALID && ALU_WA != REG_ZERO && pend_reg[ALU_WA]));

endmodule

// File: tb/tb_leve1_wb_sched.sv
// Scenario tests plus randomized traffic against a queue-based reference model.
module tb_leve1_wb_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ID_VALID, ID_WE, ID_LL, ID_FLUSH, ID_STALL;
    logic [4:0]  ID_RS1, ID_RS2, ID_RD;
    logic        ALU_WVALID;
    logic [4:0]  ALU_WA;
    logic [31:0] ALU_WD;
    logic        LL_VALID, LL_READY;
    logic [4:0]  LL_WA;
    logic [31:0] LL_WD;
    logic        WB_WE;
    logic [4:0]  WB_WA;
    logic [31:0] WB_WD;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    leve1_wb_sched dut (
        .CLK(CLK), .RST(RST),
        .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .ID_WE(ID_WE), .ID_LL(ID_LL), .ID_FLUSH(ID_FLUSH), .ID_STALL(ID_STALL),
        .ALU_WVALID(ALU_WVALID), .ALU_WA(ALU_WA), .ALU_WD(ALU_WD),
        .LL_VALID(LL_VALID), .LL_READY(LL_READY), .LL_WA(LL_WA), .LL_WD(LL_WD),
        .WB_WE(WB_WE), .WB_WA(WB_WA), .WB_WD(WB_WD), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference model: pending set, outstanding count, completion queue, last write.
    typedef struct { logic [4:0] wa; logic [31:0] wd; } ent_t;
    bit          m_pend [32];
    int          m_count = 0;
    ent_t        m_q [$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;

    function automatic bit m_stall();
        if (RST) return 1'b1;
        if (!ID_VALID) return 1'b0;
        if (ID_RS1 != 0 && m_pend[ID_RS1]) return 1'b1;
        if (ID_RS2 != 0 && m_pend[ID_RS2]) return 1'b1;
        if (ID_WE && ID_RD != 0 && m_pend[ID_RD]) return 1'b1;
        if (ID_LL && (m_count == 4 || m_q.size() == 2)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return !RST && m_q.size() < 2;
    endfunction

    task automatic model_clock();
        bit   rdy, iss;
        ent_t h;
        if (RST) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_count = 0; m_q.delete(); m_we = 0; m_wa = 0; m_wd = 0;
        end else begin
            rdy = m_ready();
            iss = ID_VALID && !m_stall() && !ID_FLUSH;
            if (ALU_WVALID) begin
                m_we = (ALU_WA != 0); m_wa = ALU_WA; m_wd = ALU_WD;
            end else if (m_q.size() > 0) begin
                h = m_q.pop_front();
                m_we = (h.wa != 0); m_wa = h.wa; m_wd = h.wd;
                m_pend[h.wa] = 1'b0;
                m_count--;
            end else begin
                m_we = 1'b0;
            end
            if (iss && ID_LL) begin
                m_count++;
                if (ID_WE && ID_RD != 0) m_pend[ID_RD] = 1'b1;
            end
            if (LL_VALID && rdy) m_q.push_back('{LL_WA, LL_WD});
        end
    endtask

    // Advance one clock; the model sees exactly the inputs the DUT samples.
    task automatic tick();
        @(posedge CLK);
        model_clock();
        @(negedge CLK);
    endtask

    task automatic idle();
        ID_VALID = 0; ID_RS1 = 0; ID_RS2 = 0; ID_RD = 0; ID_WE = 0; ID_LL = 0; ID_FLUSH = 0;
        ALU_WVALID = 0; ALU_WA = 0; ALU_WD = 0; LL_VALID = 0; LL_WA = 0; LL_WD = 0;
    endtask

    task automatic decode(input bit ll, input bit we, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input bit flush);
        ID_VALID = 1; ID_LL = ll; ID_WE = we; ID_RD = rd; ID_RS1 = rs1; ID_RS2 = rs2; ID_FLUSH = flush;
    endtask

    task automatic test_reset();
        idle(); RST = 1; ID_VALID = 1;
        tick(); tick(); #1;
        n_cmp++; if (ID_STALL !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %b want 1", ID_STALL); end
        n_cmp++; if (LL_READY !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", LL_READY); end
        n_cmp++; if (WB_WE !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", WB_WE); end
        n_cmp++; if (WB_WA !== 5'd0 || WB_WD !== 32'd0) begin n_bad++; $display("FAIL rst_wawd: got %0d/%h want 0/0", WB_WA, WB_WD); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        RST = 0; ID_VALID = 0; #1;
        n_cmp++; if (LL_READY !== 1'b1) begin n_bad++; $display("FAIL rst_rel_ready: got %b want 1", LL_READY); end
        n_cmp++; if (ID_STALL !== 1'b0) begin n_bad++; $display("FAIL rst_rel_stall: got %b want 0", ID_STALL); end
        $display("test_reset done");
    endtask

    task automatic test_ll_raw();
        idle(); decode(1, 1, 5, 0, 0, 0); #1;
        n_cmp++; if (ID_STALL !== 1'b0) begin n_bad++; $display("FAIL raw_issue: got %b want 0", ID_STALL); end
        tick();
        idle(); decode(0, 1, 6, 5, 0, 0); LL_VALID = 1; LL_WA = 5; LL_WD = 32'hDEAD; #1;
        n_cmp++; if (ID_STALL !== 1'b1) begin n_bad++; $display("FAIL raw_stall: got %b want 1", ID_STALL); end
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL raw_busy: got %b want 1", BUSY); end
        n_cmp++; if (LL_READY !== 1'b1) begin n_bad++; $display("FAIL raw_ready: got %b want 1", LL_READY); end
        tick();
        LL_VALID = 0; #1;
        n_cmp++; if (ID_STALL !== 1'b1) begin n_bad++; $display("FAIL raw_hold: got %b want 1", ID_STALL); end
        n_cmp++; if (WB_WE !== 1'b0) begin n_bad++; $display("FAIL raw_early_wb: got %b want 0", WB_WE); end
        tick();
        n_cmp++; if (WB_WE !== 1'b1 || WB_WA !== 5'd5 || WB_WD !== 32'hDEAD) begin n_bad++; $display("FAIL raw_wb: got %b/%0d/%h want 1/5/0000dead", WB_WE, WB_WA, WB_WD); end
        #1;
        n_cmp++; if (ID_STALL !== 1'b0) begin n_bad++; $display("FAIL raw_release: got %b want 0", ID_STALL); end
        tick(); idle();
        n_cmp++; if (WB_WE !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL raw_after: we=%b busy=%b want 0/0", WB_WE, BUSY); end
        $display("test_ll_raw done");
    endtask

    task automatic test_port_conflict();
        idle(); decode(1, 1, 7, 0, 0, 0); tick();
        idle(); ALU_WVALID = 1; ALU_WA = 3; ALU_WD = 32'h11; LL_VALID = 1; LL_WA = 7; LL_WD = 32'h77; #1;
        n_cmp++; if (LL_READY !== 1'b1) begin n_bad++; $display("FAIL pc_ready: got %b want 1", LL_READY); end
        tick();
        idle(); decode(0, 0, 0, 7, 0, 0);
        n_cmp++; if (WB_WE !== 1'b1 || WB_WA !== 5'd3 || WB_WD !== 32'h11) begin n_bad++; $display("FAIL pc_alu_wb: got %b/%0d/%h want 1/3/00000011", WB_WE, WB_WA, WB_WD); end
        #1;
        n_cmp++; if (ID_STALL !== 1'b1) begin n_bad++; $display("FAIL pc_pend7: got %b want 1", ID_STALL); end
        tick();
        n_cmp++; if (WB_WE !== 1'b1 || WB_WA !== 5'd7 || WB_WD !== 32'h77) begin n_bad++; $display("FAIL pc_ll_wb: got %b/%0d/%h want 1/7/00000077", WB_WE, WB_WA, WB_WD); end
        #1;
        n_cmp++; if (ID_STALL !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL pc_clear: stall=%b busy=%b want 0/0", ID_STALL, BUSY); end
        tick(); idle();
        $display("test_port_conflict done");
    endtask

    task automatic test_fifo_full();
        idle(); decode(1, 1, 10, 0, 0, 0); tick(); decode(1, 1, 11, 0, 0, 0); tick();
        idle(); ALU_WVALID = 1; ALU_WA = 1; ALU_WD = 32'hA1;
        LL_VALID = 1; LL_WA = 10; LL_WD = 32'h1010; tick();
        LL_WA = 11; LL_WD = 32'h1111; #1;
        n_cmp++; if (LL_READY !== 1'b1) begin n_bad++; $display("FAIL ff_ready1: got %b want 1", LL_READY); end
        tick();
        LL_VALID = 0; decode(1, 1, 12, 0, 0, 0); #1;
        n_cmp++; if (LL_READY !== 1'b0) begin n_bad++; $display("FAIL ff_full_ready: got %b want 0", LL_READY); end
        n_cmp++; if (ID_STALL !== 1'b1) begin n_bad++; $display("FAIL ff_full_stall: got %b want 1", ID_STALL); end
        tick();
        idle(); tick();
        n_cmp++; if (WB_WE !== 1'b1 || WB_WA !== 5'd10 || WB_WD !== 32'h1010) begin n_bad++; $display("FAIL ff_drain1: got %b/%0d/%h want 1/10/00001010", WB_WE, WB_WA, WB_WD); end
        #1;
        n_cmp++; if (LL_READY !== 1'b1) begin n_bad++; $display("FAIL ff_ready_back: got %b want 1", LL_READY); end
        tick();
        n_cmp++; if (WB_WE !== 1'b1 || WB_WA !== 5'd11 || WB_WD !== 32'h1111) begin n_bad++; $display("FAIL ff_drain2: got %b/%0d/%h want 1/11/00001111", WB_WE, WB_WA, WB_WD); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL ff_busy: got %b want 0", BUSY); end
        tick();
        $display("test_fifo_full done");
    endtask

    task automatic test_capacity_flush();
        idle(); decode(1, 1, 0, 0, 0, 0); tick();
        decode(1, 1, 13, 0, 0, 0); tick();
        decode(1, 1, 14, 0, 0, 0); tick();
        decode(1, 1, 16, 0, 0, 1); #1;
        n_cmp++; if (ID_STALL !== 1'b0) begin n_bad++; $display("FAIL cap_flush_stall: got %b want 0", ID_STALL); end
        tick();
        decode(1, 0, 15, 0, 0, 0); #1;
        n_cmp++; if (ID_STALL !== 1'b0) begin n_bad++; $display("FAIL cap_flush_count: got %b want 0", ID_STALL); end
        tick();
        decode(1, 1, 16, 0, 0, 0); #1;
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL cap_busy: got %b want 1", BUSY); end
        n_cmp++; if (ID_STALL !== 1'b1) begin n_bad++; $display("FAIL cap_stall: got %b want 1", ID_STALL); end
        ID_FLUSH = 1; #1;
        n_cmp++; if (ID_STALL !== 1'b1) begin n_bad++; $display("FAIL cap_stall_flush: got %b want 1", ID_STALL); end
        LL_VALID = 1; LL_WA = 0; LL_WD = 32'hBAD; tick();
        LL_WA = 13; LL_WD = 32'h1313; tick();
        n_cmp++; if (WB_WE !== 1'b0) begin n_bad++; $display("FAIL cap_x0_we: got %b want 0", WB_WE); end
        #1;
        n_cmp++; if (ID_STALL !== 1'b0) begin n_bad++; $display("FAIL cap_x0_count: got %b want 0", ID_STALL); end
        LL_WA = 14; LL_WD = 32'h1414; tick();
        n_cmp++; if (WB_WE !== 1'b1 || WB_WA !== 5'd13) begin n_bad++; $display("FAIL cap_wb13: got %b/%0d want 1/13", WB_WE, WB_WA); end
        LL_WA = 0; LL_WD = 32'h0; tick();
        n_cmp++; if (WB_WE !== 1'b1 || WB_WA !== 5'd14) begin n_bad++; $display("FAIL cap_wb14: got %b/%0d want 1/14", WB_WE, WB_WA); end
        idle(); tick();
        n_cmp++; if (WB_WE !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL cap_done: we=%b busy=%b want 0/0", WB_WE, BUSY); end
        $display("test_capacity_flush done");
    endtask

    task automatic test_reset_mid();
        idle(); decode(1, 1, 9, 0, 0, 0); tick(); decode(1, 1, 20, 0, 0, 0); tick();
        idle(); ALU_WVALID = 1; ALU_WA = 1; ALU_WD = 32'h5;
        LL_VALID = 1; LL_WA = 9; LL_WD = 32'h99; tick();
        LL_WA = 20; LL_WD = 32'h2020; tick();
        idle(); RST = 1; tick(); RST = 0;
        n_cmp++; if (WB_WE !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL rm_state: we=%b busy=%b want 0/0", WB_WE, BUSY); end
        #1;
        n_cmp++; if (LL_READY !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %b want 1", LL_READY); end
        decode(0, 0, 0, 9, 20, 0); #1;
        n_cmp++; if (ID_STALL !== 1'b0) begin n_bad++; $display("FAIL rm_pend: got %b want 0", ID_STALL); end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (WB_WE !== 1'b0) begin n_bad++; $display("FAIL rm_stale%0d: got %b want 0", i, WB_WE); end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [4:0] await_q [$];
        int         idx;
        bit         hs, iss_ll;
        idle(); RST = 1; tick(); RST = 0;
        for (int c = 0; c < 600; c++) begin
            RST        = ($urandom_range(0, 199) == 0);
            ID_VALID   = ($urandom_range(0, 99) < 60);
            ID_RS1     = 5'($urandom_range(0, 7));
            ID_RS2     = 5'($urandom_range(0, 7));
            ID_RD      = 5'($urandom_range(0, 7));
            ID_WE      = 1'($urandom_range(0, 1));
            ID_LL      = ($urandom_range(0, 99) < 40);
            ID_FLUSH   = ($urandom_range(0, 99) < 15);
            ALU_WVALID = ($urandom_range(0, 99) < 35);
            ALU_WA     = 5'($urandom_range(0, 7));
            if (m_pend[ALU_WA]) ALU_WA = 0;
            ALU_WD     = $urandom;
            LL_VALID   = (await_q.size() > 0) && ($urandom_range(0, 99) < 60);
            idx        = 0;
            if (LL_VALID) begin
                idx   = $urandom_range(0, await_q.size() - 1);
                LL_WA = await_q[idx];
            end else begin
                LL_WA = 5'($urandom_range(0, 7));
            end
            LL_WD = $urandom;
            #1;
            n_cmp++; if (ID_STALL !== m_stall()) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, ID_STALL, m_stall()); end
            n_cmp++; if (LL_READY !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, LL_READY, m_ready()); end
            n_cmp++; if (BUSY !== (m_count != 0)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, BUSY, m_count != 0); end
            hs     = LL_VALID && m_ready();
            iss_ll = ID_VALID && !m_stall() && !ID_FLUSH && ID_LL;
            tick();
            if (RST) begin
                await_q.delete();
            end else begin
                if (hs) await_q.delete(idx);
                if (iss_ll) await_q.push_back(ID_WE ? ID_RD : 5'd0);
            end
            n_cmp++; if (WB_WE !== m_we || WB_WA !== m_wa || WB_WD !== m_wd) begin n_bad++; $display("FAIL rnd_wb c%0d: got %b/%0d/%h want %b/%0d/%h", c, WB_WE, WB_WA, WB_WD, m_we, m_wa, m_wd); end
            if (m_we) $display("cycle %0d: wb x%0d <= %h", c, m_wa, m_wd);
        end
        idle(); RST = 0;
        $display("test_random done");
    endtask

    initial begin
        idle(); RST = 1;
        test_reset();
        test_ll_raw();
        test_port_conflict();
        test_fifo_full();
        test_capacity_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
